// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding, default
// operand width and the bit-counter width helper.
package serial_subtractor_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int DEFAULT_WIDTH = 4;

    // Counter must be able to index every bit position 0..WIDTH-1 and
    // is sized to hold WIDTH itself for headroom.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: diff = a - b - borrow_in, purely combinational.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    // Borrow is generated when a=0,b=1, or propagated when a==b.
    always_comb begin
        diff       = a ^ b ^ borrow_in;
        borrow_out = (~a & b) | (~(a ^ b) & borrow_in);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, WIDTH cycles per operation behind a start/done handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = cnt_width(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;

    logic             fs_diff;
    logic             fs_borrow;
    logic             load;
    logic             last_bit;
    logic [WIDTH-1:0] work_shift;

    full_subtractor u_fs (
        .a          (a_q[0]),
        .b          (b_q[0]),
        .borrow_in  (br_q),
        .diff       (fs_diff),
        .borrow_out (fs_borrow)
    );

    // A request is only honoured when no operation is in flight.
    assign load     = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: DONE re-accepts start so operations can run back-to-back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode straight from the state register.
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // Datapath next-state: load operands, then shift one bit per RUN cycle.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        br_d   = br_q;
        work_d = work_q;
        cnt_d  = cnt_q;
        diff_d = diff_q;
        bout_d = bout_q;

        // Result bits enter at the MSB so after WIDTH shifts bit 0 is the LSB.
        work_shift             = work_q >> 1;
        work_shift[WIDTH-1]    = fs_diff;

        if (load) begin
            a_d    = a;
            b_d    = b;
            br_d   = borrow_in;
            work_d = '0;
            cnt_d  = '0;
        end else if (state_q == RUN) begin
            a_d    = a_q >> 1;
            b_d    = b_q >> 1;
            br_d   = fs_borrow;
            work_d = work_shift;
            cnt_d  = cnt_q + CW'(1);
            // Publish only the finished word so partial shifts stay hidden.
            if (last_bit) begin
                diff_d = work_shift;
                bout_d = fs_borrow;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            br_q   <= 1'b0;
            work_q <= '0;
            cnt_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            br_q   <= br_d;
            work_q <= work_d;
            cnt_q  <= cnt_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
        end
    end

    assign diff       = diff_q;
    assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4 and WIDTH=8.
module tb_serial_subtractor;

    typedef struct {
        int unsigned d;
        int unsigned bo;
        int          t;   // edge that samples the accepted start
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    exp_t q4[$];
    exp_t q8[$];

    logic       rst4 = 1'b1, start4 = 1'b0, bi4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, bo4;
    logic [3:0] diff4;

    logic       rst8 = 1'b1, start8 = 1'b0, bi8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bo8;
    logic [7:0] diff8;

    int bcnt4 = 0;
    int bcnt8 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .borrow_in(bi4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .borrow_in(bi8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int a, input int b, input int bi, input int w, input int t);
        exp_t e;
        int   r;
        r    = a - b - bi;
        e.d  = r & ((1 << w) - 1);
        e.bo = (r < 0) ? 1 : 0;
        e.t  = t;
        return e;
    endfunction

    // WIDTH=4 result monitor.
    always @(negedge clk) begin
        if (rst4) begin
            bcnt4 = 0;
        end else begin
            if (busy4 && done4) chk("excl4", 1, 0);
            if (busy4) bcnt4++;
            if (done4) begin
                if (q4.size() == 0) begin
                    chk("spurious_done4", 1, 0);
                end else begin
                    exp_t e;
                    e = q4.pop_front();
                    chk("diff4", int'(diff4), int'(e.d));
                    chk("bout4", int'(bo4), int'(e.bo));
                    chk("lat4", cyc - e.t, 4);
                    chk("busy_len4", bcnt4, 4);
                end
                bcnt4 = 0;
            end
        end
    end

    // WIDTH=8 result monitor.
    always @(negedge clk) begin
        if (rst8) begin
            bcnt8 = 0;
        end else begin
            if (busy8 && done8) chk("excl8", 1, 0);
            if (busy8) bcnt8++;
            if (done8) begin
                if (q8.size() == 0) begin
                    chk("spurious_done8", 1, 0);
                end else begin
                    exp_t e;
                    e = q8.pop_front();
                    chk("diff8", int'(diff8), int'(e.d));
                    chk("bout8", int'(bo8), int'(e.bo));
                    chk("lat8", cyc - e.t, 8);
                    chk("busy_len8", bcnt8, 8);
                end
                bcnt8 = 0;
            end
        end
    end

    task automatic wait4();
        for (int i = 0; i < 40 && q4.size() != 0; i++) @(negedge clk);
        if (q4.size() != 0) begin
            chk("timeout4", q4.size(), 0);
            q4.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait8();
        for (int i = 0; i < 60 && q8.size() != 0; i++) @(negedge clk);
        if (q8.size() != 0) begin
            chk("timeout8", q8.size(), 0);
            q8.delete();
        end
        @(negedge clk);
    endtask

    task automatic op4(input int a, input int b, input int bi);
        a4 = 4'(a); b4 = 4'(b); bi4 = bi[0]; start4 = 1'b1;
        q4.push_back(model(a, b, bi, 4, cyc + 1));
        @(negedge clk);
        start4 = 1'b0;
        wait4();
    endtask

    task automatic op8(input int a, input int b, input int bi);
        a8 = 8'(a); b8 = 8'(b); bi8 = bi[0]; start8 = 1'b1;
        q8.push_back(model(a, b, bi, 8, cyc + 1));
        @(negedge clk);
        start8 = 1'b0;
        wait8();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, WIDTH=4.
        repeat (2) @(negedge clk);
        chk("rst_busy4", int'(busy4), 0);
        chk("rst_done4", int'(done4), 0);
        chk("rst_diff4", int'(diff4), 0);
        chk("rst_bout4", int'(bo4), 0);
        rst4 = 1'b0;
        @(negedge clk);

        op4(9, 3, 0);
        op4(3, 9, 0);
        op4(0, 0, 1);
        op4(15, 15, 1);

        // start pulsed mid-RUN with other operands must be ignored.
        a4 = 4'd5; b4 = 4'd2; bi4 = 1'b0; start4 = 1'b1;
        q4.push_back(model(5, 2, 0, 4, cyc + 1));
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        a4 = 4'd15; b4 = 4'd0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait4();
        repeat (8) @(negedge clk);

        // Back-to-back: start held through DONE.
        a4 = 4'd6; b4 = 4'd1; bi4 = 1'b0; start4 = 1'b1;
        q4.push_back(model(6, 1, 0, 4, cyc + 1));
        @(negedge clk);
        a4 = 4'd7; b4 = 4'd2;
        q4.push_back(model(7, 2, 0, 4, cyc + 5));
        repeat (5) @(negedge clk);
        chk("b2b_busy4", int'(busy4), 1);
        start4 = 1'b0;
        wait4();

        // Reset during the second RUN cycle aborts the operation.
        a4 = 4'd12; b4 = 4'd5; bi4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        chk("abort_busy4", int'(busy4), 0);
        chk("abort_done4", int'(done4), 0);
        chk("abort_diff4", int'(diff4), 0);
        chk("abort_bout4", int'(bo4), 0);
        rst4 = 1'b0;
        repeat (10) @(negedge clk);
        chk("sb_empty4", q4.size(), 0);

        // WIDTH=8 instance.
        chk("rst_diff8", int'(diff8), 0);
        chk("rst_busy8", int'(busy8), 0);
        rst8 = 1'b0;
        @(negedge clk);
        op8(200, 100, 0);
        op8(10, 20, 1);
        op8(255, 0, 1);
        repeat (4) @(negedge clk);
        chk("sb_empty8", q8.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
